// File: rtl/cam_pkg.sv
// Shared constants and types for the OV7670 RGB444 capture path.
// Default geometry matches the 160x120 frame buffer read by the VGA side.
package cam_pkg;

  localparam int IMG_W    = 160;
  localparam int IMG_H    = 120;
  localparam int PX_TOTAL = IMG_W * IMG_H;
  localparam int AW       = 15;
  localparam int DW       = 12;

  // Bit positions of each 4-bit colour field inside a packed pixel
  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_BYTE1      = 2'd1,
    ST_BYTE2      = 2'd2
  } cam_state_e;

  // byte 1 carries red in its low nibble, byte 2 carries {green, blue}
  function automatic logic [11:0] pack_rgb444(input logic [3:0] red,
                                              input logic [7:0] gb);
    logic [11:0] px;
    px             = '0;
    px[R_LSB +: 4] = red;
    px[G_LSB +: 4] = gb[7:4];
    px[B_LSB +: 4] = gb[3:0];
    return px;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer with a one-clk pulse on each synced 0->1 transition.
// RST_VAL is the level the synchronizer assumes while in reset.
module cam_sync_edge
  import cam_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1;
  logic s2;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1   <= d;
      s2   <= s1;
      s2_q <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s2_q;

endmodule

// File: rtl/cam_capture_rgb444.sv
// OV7670 capture: oversamples the camera bus on clk, packs byte pairs into
// RGB444 words and writes them row-major into the frame buffer.
module cam_capture_rgb444 #(
  parameter int IMG_W = cam_pkg::IMG_W,
  parameter int IMG_H = cam_pkg::IMG_H,
  parameter int AW    = cam_pkg::AW,
  parameter int DW    = cam_pkg::DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CAM_pclk,
  input  logic                CAM_vsync,
  input  logic                CAM_href,
  input  logic [7:0]          CAM_px_data,
  output logic [AW-1:0]       mem_px_addr,
  output logic [DW-1:0]       mem_px_data,
  output logic                mem_px_wr,
  output logic                frame_done,
  output logic                px_overflow,
  output cam_pkg::cam_state_e dbg_state
);

  localparam logic [AW-1:0] PX_LAST = AW'(IMG_W * IMG_H - 1);

  // Write interface: mem_px_wr is a one-clk strobe with no back-pressure;
  // mem_px_addr and mem_px_data are valid in exactly the cycle it is high.

  logic       pclk_s;
  logic       pclk_rise;
  logic       href_s1, href_s;
  logic       vsync_s1, vsync_s;
  logic [7:0] data_d1, data_s;

  cam_sync_edge #(.RST_VAL(1'b0)) u_pclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (CAM_pclk),
    .q    (pclk_s),
    .rise (pclk_rise)
  );

  // href/vsync/data share the pclk pipeline depth so they line up with pclk_rise
  always_ff @(posedge clk) begin
    if (rst) begin
      href_s1  <= 1'b0;
      href_s   <= 1'b0;
      vsync_s1 <= 1'b1;
      vsync_s  <= 1'b1;
      data_d1  <= '0;
      data_s   <= '0;
    end else begin
      href_s1  <= CAM_href;
      href_s   <= href_s1;
      vsync_s1 <= CAM_vsync;
      vsync_s  <= vsync_s1;
      data_d1  <= CAM_px_data;
      data_s   <= data_d1;
    end
  end

  cam_pkg::cam_state_e state, state_n;
  logic       vs_seen;
  logic       seen_set;
  logic       latch_red;
  logic       wr_req;
  logic       frame_end;
  logic [3:0] red_q;
  logic       full_q;
  logic       written_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= cam_pkg::ST_WAIT_FRAME;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    seen_set  = 1'b0;
    latch_red = 1'b0;
    wr_req    = 1'b0;
    frame_end = 1'b0;
    if (pclk_rise) begin
      case (state)
        cam_pkg::ST_WAIT_FRAME: begin
          // a frame opens only on a vsync falling edge seen since reset
          if (vsync_s) begin
            seen_set = 1'b1;
          end else if (vs_seen) begin
            state_n = cam_pkg::ST_BYTE1;
          end
        end
        cam_pkg::ST_BYTE1: begin
          if (vsync_s) begin
            frame_end = 1'b1;
            state_n   = cam_pkg::ST_WAIT_FRAME;
          end else if (href_s) begin
            latch_red = 1'b1;
            state_n   = cam_pkg::ST_BYTE2;
          end
        end
        cam_pkg::ST_BYTE2: begin
          // href low here drops the half pixel at line end
          if (vsync_s) begin
            frame_end = 1'b1;
            state_n   = cam_pkg::ST_WAIT_FRAME;
          end else begin
            wr_req  = href_s;
            state_n = cam_pkg::ST_BYTE1;
          end
        end
        default: state_n = cam_pkg::ST_WAIT_FRAME;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_seen     <= 1'b0;
      red_q       <= '0;
      full_q      <= 1'b0;
      written_q   <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      mem_px_wr   <= 1'b0;
      frame_done  <= 1'b0;
      px_overflow <= 1'b0;
    end else begin
      mem_px_wr  <= 1'b0;
      frame_done <= 1'b0;
      if (seen_set) vs_seen <= 1'b1;
      if (latch_red) red_q <= data_s[3:0];
      if (frame_end) begin
        frame_done  <= written_q;
        mem_px_addr <= '0;
        px_overflow <= 1'b0;
        full_q      <= 1'b0;
        written_q   <= 1'b0;
      end else begin
        if (wr_req) begin
          if (full_q) begin
            px_overflow <= 1'b1;
          end else begin
            mem_px_wr   <= 1'b1;
            mem_px_data <= DW'(cam_pkg::pack_rgb444(red_q, data_s));
            written_q   <= 1'b1;
          end
        end
        // address advances after the write; the last address is held, never wrapped
        if (mem_px_wr) begin
          if (mem_px_addr == PX_LAST) begin
            full_q <= 1'b1;
          end else begin
            mem_px_addr <= mem_px_addr + 1'b1;
          end
        end
      end
    end
  end

  assign dbg_state = state;

endmodule
